alu_sequencer: RTL

- Issue side of the 8-bit ALU interface.
- Holds a small program memory and a 4 x 8-bit register file.
- Fetches 16-bit instructions and drives ALU operands and the 3-bit opcode.
- Samples the ALU result, overflow and branch flag, writes results back, and steers the PC on branch-equal / branch-not-equal.
- Sits between the host/testbench load port and the combinational ALU.

---
 rtl/alu_seq_pkg.sv | 39 +++
 rtl/alu_seq_if.sv | 21 ++
 rtl/alu_seq_regfile.sv | 39 +++
 rtl/alu_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states and
// instruction field positions.
package alu_seq_pkg;

  localparam int INSTR_W = 16;

  // Opcodes use the ALU's own encoding so they can be forwarded unchanged.
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NOTB = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_BNE  = 3'b111;

  // Instruction field bit positions; the branch target sits at [PC_W-1:0].
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 13;
  localparam int RD_MSB = 12;
  localparam int RD_LSB = 11;
  localparam int RA_MSB = 10;
  localparam int RA_LSB = 9;
  localparam int RB_MSB = 8;
  localparam int RB_LSB = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_EXEC   = 2'd3
  } state_t;

  // Both branch opcodes share the 11x prefix and never write back.
  function automatic logic is_branch(input logic [2:0] op);
    return (op[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Bus between the sequencer (master) and the combinational ALU (slave).
interface alu_seq_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_s;
  logic [DATA_W-1:0] alu_f;
  logic              alu_ovf;
  logic              alu_take_branch;

  modport master (
    output alu_a, alu_b, alu_s,
    input  alu_f, alu_ovf, alu_take_branch
  );

  modport slave (
    input  alu_a, alu_b, alu_s,
    output alu_f, alu_ovf, alu_take_branch
  );
endinterface

// File: rtl/alu_seq_regfile.sv
// 4-entry register file: one write port, two operand read ports and one
// debug read port, all reads combinational.
module alu_seq_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [1:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [1:0]        i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [1:0]        i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic [1:0]        i_raddr_dbg,
  output logic [DATA_W-1:0] o_rdata_dbg
);

  logic [DATA_W-1:0] r_mem [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_entry
      // Each entry clears on reset and loads when addressed by the write port.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_mem[gi] <= '0;
        end else if (i_we && (i_waddr == 2'(gi))) begin
          r_mem[gi] <= i_wdata;
        end
      end
    end
  endgenerate

  assign o_rdata_a   = r_mem[i_raddr_a];
  assign o_rdata_b   = r_mem[i_raddr_b];
  assign o_rdata_dbg = r_mem[i_raddr_dbg];

endmodule

// File: rtl/alu_sequencer.sv
// Issue side of the 8-bit ALU: program memory, register file and a
// FETCH/DECODE/EXEC sequencer driving the ALU bus.
// Optional step limit with abort output: define ALU_SEQ_STEP_LIMIT_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int PC_W      = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_STEPS = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PC_W-1:0]   end_addr,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [15:0]       prog_data,
  input  logic              reg_we,
  input  logic [1:0]        reg_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [1:0]        rf_raddr,
  output logic [DATA_W-1:0] rf_rdata,
  alu_seq_if.master         alu,
  output logic              busy,
  output logic              done,
`ifdef ALU_SEQ_STEP_LIMIT_EN
  output logic              abort,
`endif
  output logic              ovf_sticky
);

  state_t                r_state;
  state_t                w_state_next;
  logic [PC_W-1:0]       r_pc;
  logic [PC_W-1:0]       r_end_addr;
  logic [INSTR_W-1:0]    r_instr;
  logic [INSTR_W-1:0]    r_prog_mem [0:(1<<PC_W)-1];
  logic [DATA_W-1:0]     r_alu_a;
  logic [DATA_W-1:0]     r_alu_b;
  logic [2:0]            r_alu_s;
  logic                  r_done;
  logic                  r_ovf;
  logic                  w_busy;

  logic [2:0]            w_op;
  logic [1:0]            w_rd;
  logic [1:0]            w_ra;
  logic [1:0]            w_rb;
  logic [PC_W-1:0]       w_target;
  logic                  w_take;
  logic                  w_halt;
  logic                  w_step_abort;
  logic [PC_W-1:0]       w_pc_next;
  logic                  w_rf_we;
  logic [1:0]            w_rf_waddr;
  logic [DATA_W-1:0]     w_rf_wdata;
  logic [DATA_W-1:0]     w_rdata_a;
  logic [DATA_W-1:0]     w_rdata_b;
  logic                  w_idle;
  logic                  w_unused_instr;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_op     = r_instr[OP_MSB:OP_LSB];
  assign w_rd     = r_instr[RD_MSB:RD_LSB];
  assign w_ra     = r_instr[RA_MSB:RA_LSB];
  assign w_rb     = r_instr[RB_MSB:RB_LSB];
  assign w_target = r_instr[PC_W-1:0];
  // Bits between the rb field and the target are reserved.
  assign w_unused_instr = ^r_instr;

  // A branch redirects only when the ALU confirms the comparison.
  assign w_take    = alu.alu_take_branch && is_branch(w_op);
  assign w_halt    = (r_pc == r_end_addr) && !w_take;
  assign w_pc_next = w_take ? w_target : r_pc + 1'b1;

`ifdef ALU_SEQ_STEP_LIMIT_EN
  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  logic [STEP_W-1:0] r_steps;
  logic              r_abort;

  // Runaway programs are cut off after MAX_STEPS executed instructions.
  assign w_step_abort = ((r_steps + STEP_W'(1)) == STEP_W'(MAX_STEPS)) && !w_halt;
  assign abort        = r_abort;

  // Executed-instruction counter and abort pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_steps <= '0;
      r_abort <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      if (w_idle && start) begin
        r_steps <= '0;
      end else if (r_state == ST_EXEC) begin
        r_steps <= r_steps + STEP_W'(1);
        r_abort <= w_step_abort;
      end
    end
  end
`else
  localparam int unused_max_steps = MAX_STEPS;
  assign w_step_abort = 1'b0;
`endif

  // Host writes land only while idle; EXEC writes back non-branch results.
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = reg_addr;
    w_rf_wdata = reg_data;
    if (w_idle) begin
      w_rf_we = reg_we;
    end else if (r_state == ST_EXEC) begin
      w_rf_we    = !is_branch(w_op);
      w_rf_waddr = w_rd;
      w_rf_wdata = alu.alu_f;
    end
  end

  alu_seq_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .i_we        (w_rf_we),
    .i_waddr     (w_rf_waddr),
    .i_wdata     (w_rf_wdata),
    .i_raddr_a   (w_ra),
    .o_rdata_a   (w_rdata_a),
    .i_raddr_b   (w_rb),
    .o_rdata_b   (w_rdata_b),
    .i_raddr_dbg (rf_raddr),
    .o_rdata_dbg (rf_rdata)
  );

  // Program memory: unreset block RAM with a registered fetch read.
  always_ff @(posedge clk) begin
    if (prog_we && w_idle) begin
      r_prog_mem[prog_addr] <= prog_data;
    end
    if (r_state == ST_FETCH) begin
      r_instr <= r_prog_mem[r_pc];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_next = ST_FETCH;
      ST_FETCH:  w_state_next = ST_DECODE;
      ST_DECODE: w_state_next = ST_EXEC;
      ST_EXEC:   w_state_next = (w_halt || w_step_abort) ? ST_IDLE : ST_FETCH;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    w_busy = (r_state != ST_IDLE);
  end

  // Datapath: PC, ALU operand registers, done pulse and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= '0;
      r_end_addr <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_s    <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pc       <= '0;
            r_end_addr <= end_addr;
            r_ovf      <= 1'b0;
          end
        end
        ST_DECODE: begin
          r_alu_a <= w_rdata_a;
          r_alu_b <= w_rdata_b;
          r_alu_s <= w_op;
        end
        ST_EXEC: begin
          if (w_op == OP_ADD) begin
            r_ovf <= r_ovf | alu.alu_ovf;
          end
          r_pc   <= w_pc_next;
          r_done <= w_halt || w_step_abort;
        end
        default: ;
      endcase
    end
  end

  assign alu.alu_a  = r_alu_a;
  assign alu.alu_b  = r_alu_b;
  assign alu.alu_s  = r_alu_s;
  assign busy       = w_busy;
  assign done       = r_done;
  assign ovf_sticky = r_ovf;

endmodule
